// File: rtl/nand_lab_pkg.sv
// -----------------------------------------------------------------------------
// nand_lab_pkg
// Shared types and the golden NAND function for the NAND-gate lab checker.
//   state_t     : checker FSM states
//   vec_t       : applied stimulus vector {a,b,c,d}, a is the MSB
//   resp_t      : DUT response {e,f,g}, e is the MSB
//   golden_nand : expected response for a given stimulus vector
// -----------------------------------------------------------------------------
package nand_lab_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VEC,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  typedef logic [3:0] vec_t;
  typedef logic [2:0] resp_t;

  // Width of the settle down-counter; covers a load value of up to 14.
  localparam int unsigned SETTLE_W = 4;

  // Width of the compared-vector counter; holds up to 16.
  localparam int unsigned VCNT_W = 5;

  // e and f are two independent NANDs; g is the NAND of those two results.
  function automatic resp_t golden_nand(input vec_t v);
    logic e;
    logic f;
    logic g;
    e = ~(v[3] & v[2]);
    f = ~(v[1] & v[0]);
    g = ~(e & f);
    return {e, f, g};
  endfunction

endpackage

// File: rtl/nand_settle_timer.sv
// -----------------------------------------------------------------------------
// nand_settle_timer
// Loadable down-counter that times the settle interval between accepting a
// vector and sampling the DUT response. It stops at zero rather than wrapping.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   load     : load load_val this cycle (takes priority over en)
//   load_val : value to load
//   en       : decrement this cycle if the count is non-zero
//   zero     : count currently reads zero
// -----------------------------------------------------------------------------
module nand_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nand_response_checker.sv
// -----------------------------------------------------------------------------
// nand_response_checker
// Receiving end of the 4-input toggle stimulus pattern. Each accepted vector is
// held, a settle interval is timed, then the 3-bit DUT response is compared
// against the golden NAND function. Status accumulates over one run of
// NUM_VECTORS vectors; done/pass report the run result.
// Parameters:
//   SETTLE_CYCLES : clocks spent settling after acceptance (1..15)
//   NUM_VECTORS   : vectors per run before done (1..16)
//   ERR_W         : width of the saturating error counter
// Ports:
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset
//   start           : one-cycle pulse, clears status and begins a run
//   vec_valid       : vec_in holds a newly applied vector
//   vec_in          : applied vector {a,b,c,d}
//   resp_in         : DUT response {e,f,g}
//   ready           : checker accepts a vector this cycle
//   mismatch        : one-cycle pulse after a wrong response was compared
//   err_count       : mismatches this run, saturating at all-ones
//   vec_count       : vectors compared this run
//   first_err_valid : first_err_vec holds a captured vector
//   first_err_vec   : first failing vector of this run
//   done            : run complete, held until the next start
//   pass            : meaningful while done=1; 1 means no errors
// Timing: response sampled SETTLE_CYCLES+1 clocks after the acceptance edge;
// mismatch and counters update on that sampling edge.
// -----------------------------------------------------------------------------
module nand_response_checker
  import nand_lab_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_VECTORS   = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec_in,
  input  logic [2:0]       resp_in,
  output logic             ready,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       vec_count,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec,
  output logic             done,
  output logic             pass
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [VCNT_W-1:0]   RUN_LEN     = VCNT_W'(NUM_VECTORS);

  state_t               state;
  vec_t                 vec_q;       // vector under test, held through SETTLE/COMPARE
  logic                 tmr_load;
  logic [SETTLE_W-1:0]  tmr_val;
  logic                 tmr_en;
  logic                 tmr_zero;
  logic                 resp_bad;
  logic [ERR_W-1:0]     err_count_nxt;
  logic [VCNT_W-1:0]    vec_count_nxt;

  // ---------------------------------------------------------------------------
  // Settle timer. A start pulse reloads it with zero so an aborted run leaves
  // no stale count behind; otherwise it is armed on vector acceptance.
  // ---------------------------------------------------------------------------
  assign tmr_load = start || ((state == WAIT_VEC) && vec_valid);
  assign tmr_val  = start ? '0 : SETTLE_LOAD;
  assign tmr_en   = (state == SETTLE);

  nand_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // ---------------------------------------------------------------------------
  // Compare-cycle arithmetic. Only consumed in COMPARE; pass needs the
  // post-update error count, so it is computed here once.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default on entry, so
  // no path leaves it holding its old value and no latch is inferred.
  always_comb begin
    resp_bad      = 1'b0;
    err_count_nxt = err_count;
    vec_count_nxt = vec_count + VCNT_W'(1);
    if (resp_in != golden_nand(vec_q)) begin
      resp_bad = 1'b1;
    end
    if (resp_bad && (err_count != '1)) begin
      err_count_nxt = err_count + ERR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. start overrides everything else in
  // every state, which is what gives it priority over vec_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      vec_q           <= '0;
      ready           <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      vec_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      // mismatch is a single-cycle pulse; only COMPARE raises it.
      mismatch <= 1'b0;

      if (start) begin
        state           <= WAIT_VEC;
        ready           <= 1'b1;
        err_count       <= '0;
        vec_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
        done            <= 1'b0;
        pass            <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ready <= 1'b0;
          end

          WAIT_VEC: begin
            if (vec_valid) begin
              vec_q <= vec_in;
              state <= SETTLE;
              ready <= 1'b0;
            end
          end

          // vec_valid is deliberately not looked at here: vectors applied
          // while settling are dropped, not queued.
          SETTLE: begin
            if (tmr_zero) begin
              state <= COMPARE;
            end
          end

          COMPARE: begin
            vec_count <= vec_count_nxt;
            err_count <= err_count_nxt;
            if (resp_bad) begin
              mismatch <= 1'b1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= vec_q;
              end
            end
            if (vec_count_nxt == RUN_LEN) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_count_nxt == '0);
            end else begin
              state <= WAIT_VEC;
              ready <= 1'b1;
            end
          end

          DONE: begin
            done <= 1'b1;
          end

          default: begin
            state <= IDLE;
            ready <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
